ex_muldiv_ctrl: RTL and testbench
=================================

Name: ex_muldiv_ctrl

Overview:
Sequencer for an iterative RV32M multiply/divide unit shared by the EX stage. Accepts one M-extension op from the ID/EX register and runs a shift-add multiply or restoring divide over XLEN cycles. Holds the pipeline through md_stall, which is ORed into combined_stall, and returns the result to the EX/MEM register with a valid/ready handshake.

Parameters:
XLEN, 32, operand/result width; must be even and at least 8
CNT_W, $clog2(XLEN), iteration counter width (derived; do not override)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
start  in  1  decoded M-op valid in EX (decode_enable_out & funct7==7'b0000001)
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  XLEN  rs1 value
op_b  in  XLEN  rs2 value
rd_in  in  5  destination register
flush  in  1  kill in-flight op (branch/exception)
result_ready  in  1  EX/MEM can take the result
md_stall  out  1  hold the IF/ID/EX stages
result_valid  out  1  result and result_rd are valid
result  out  XLEN  final value
result_rd  out  5  destination of result
busy  out  1  state != IDLE

Behaviour:
- Synchronous active-low reset: state=IDLE, count=0, result=0, result_rd=0, result_valid=0, busy=0. md_stall is 0 unless start=1.
- States: IDLE, BUSY, FIX, DONE.
- IDLE, start=1, flush=0: latch funct3 and rd_in. Latch |op_a| and |op_b| where the operand is signed for the op, plus the result-sign flags. Then:
  - divide op with op_b==0: go to DONE. DIV/DIVU give all-ones; REM/REMU give op_a.
  - DIV/REM with op_a==INT_MIN and op_b==-1: go to DONE. DIV gives INT_MIN; REM gives 0.
  - all other ops: go to BUSY with count=0.
- BUSY: one radix-2 step per cycle on a 2*XLEN accumulator. Exit to FIX when count==XLEN-1.
- FIX: apply two's-complement sign correction. Select low word (MUL, DIV*) or high word (MULH*, REM*). Load result, then go to DONE.
- DONE: result_valid=1, result_rd=latched rd. If result_ready=1, go to IDLE the next cycle; otherwise hold result and result_valid.
- Latency (normal ops): start sampled at edge 0, result_valid high after edge XLEN+2 (34 cycles). Special cases: result_valid high after edge 1.
- md_stall = start&IDLE | BUSY | FIX | (DONE & !result_ready). It is combinational so the issuing cycle is already stalled.
- start is ignored outside IDLE. A new op can be accepted in the cycle after the DONE handshake.
- flush: in any state, go to IDLE next edge with result_valid=0 and no result produced. flush has priority over start and over result_ready.
- Reset asserted mid-operation behaves identically to power-on reset.
- result_valid never rises without a prior accepted start.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a combinational XLEN x XLEN multiplier. They go IDLE->FIX->DONE, with result_valid after edge 2. Divides are unchanged.
- Undefined: all multiplies iterate through BUSY (XLEN cycles). No hardware multiplier is inferred.

Decomposition:
- Shared package core_pkg: md_state_t enum {IDLE, BUSY, FIX, DONE}, funct3 op constants (F3_MUL..F3_REMU), M-extension funct7 constant 7'b0000001.
- Sub-module muldiv_step (combinational): one shift-add or restore-subtract iteration over the accumulator. The controller owns all state, the counter and sign logic.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD, result_ready=1 -> result=0xFFFFFFEB, result_valid exactly after edge 34, md_stall high for cycles 0..33.
- MULH op_a=op_b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU op_a=0xFFFFFFFF, op_b=2 -> 0xFFFFFFFF.
- DIVU 100/0 -> 0xFFFFFFFF after edge 1; REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 7/2 -> 1, each after edge 34.
- Backpressure: result_ready=0 for 3 cycles in DONE -> result, result_valid and md_stall held; start pulses during DONE ignored; ready=1 -> IDLE next cycle.
- flush at edge 10 of a DIV -> IDLE at edge 11, result_valid never asserts. reset_n low at edge 5 of a MUL -> all outputs 0 next edge. A fresh MUL afterwards completes correctly.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared M-extension decode constants and muldiv sequencer state type
package core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } md_state_t;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// rtl/ex_muldiv_ctrl_if.sv - issue/result bundle between the EX stage and the muldiv sequencer
interface ex_muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            flush;
    logic            result_ready;
    logic            md_stall;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      result_rd;
    logic            busy;

    modport master (
        output start, funct3, op_a, op_b, rd_in, flush, result_ready,
        input  md_stall, result_valid, result, result_rd, busy
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, flush, result_ready,
        output md_stall, result_valid, result, result_rd, busy
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 shift-add multiply or restoring-divide iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh[XLEN-1:0] - operand;
        acc_next = '0;
        if (is_div) begin
            if (rem_sh >= {1'b0, operand}) begin
                acc_next = {diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {add_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// rtl/ex_muldiv_ctrl.sv - RV32M iterative multiply/divide sequencer (MULDIV_FAST_MUL_EN: single-pass multiplier)
module ex_muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    ex_muldiv_ctrl_if.slave md
);
    import core_pkg::*;

    localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN-1);

    md_state_t         state;
    md_state_t         state_nx;
    logic [CNT_W-1:0]  count;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb_q;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   res_q;

    logic              a_signed;
    logic              b_signed;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic              fast_mul;
    logic [2*XLEN-1:0] acc_init;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;
    logic              md_stall;
    logic              accept;

    // Operands are reduced to magnitudes up front; the sign is reapplied in FIX.
    always_comb begin
        a_signed = (md.funct3 == F3_MULH) || (md.funct3 == F3_MULHSU) ||
                   (md.funct3 == F3_DIV)  || (md.funct3 == F3_REM);
        b_signed = (md.funct3 == F3_MULH) || (md.funct3 == F3_DIV) || (md.funct3 == F3_REM);
        sa       = a_signed && md.op_a[XLEN-1];
        sb       = b_signed && md.op_b[XLEN-1];
        a_mag    = sa ? -md.op_a : md.op_a;
        b_mag    = sb ? -md.op_b : md.op_b;
        div_zero = md.funct3[2] && (md.op_b == '0);
        div_ovf  = ((md.funct3 == F3_DIV) || (md.funct3 == F3_REM)) &&
                   (md.op_a == INT_MIN) && (md.op_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = md.funct3[1] ? md.op_a : '1;
        end else begin
            special_res = md.funct3[1] ? '0 : INT_MIN;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul = !md.funct3[2];
    assign acc_init = fast_mul ? ({{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag})
                               : {{XLEN{1'b0}}, a_mag};
`else
    assign fast_mul = 1'b0;
    assign acc_init = {{XLEN{1'b0}}, a_mag};
`endif

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div   (f3_q[2]),
        .acc      (acc),
        .operand  (opb_q),
        .acc_next (acc_step)
    );

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                       fix_res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = quo;
            default:                      fix_res = rem;
        endcase
    end

    assign accept = (state == IDLE) && md.start && !md.flush;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        md_stall = 1'b0;
        case (state)
            IDLE: begin
                md_stall = md.start;
                if (accept) begin
                    if (special) begin
                        state_nx = DONE;
                    end else if (fast_mul) begin
                        state_nx = FIX;
                    end else begin
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                md_stall = 1'b1;
                if (count == LAST) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                md_stall = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                md_stall = !md.result_ready;
                if (md.result_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (md.flush) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            f3_q  <= '0;
            rd_q  <= '0;
            acc   <= '0;
            opb_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q  <= md.funct3;
                        rd_q  <= md.rd_in;
                        opb_q <= b_mag;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        count <= '0;
                        acc   <= acc_init;
                        if (special) begin
                            res_q <= special_res;
                        end
                    end
                end
                BUSY: begin
                    acc   <= acc_step;
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    if (!md.flush) begin
                        res_q <= fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md.md_stall     = md_stall;
    assign md.result_valid = (state == DONE);
    assign md.result       = res_q;
    assign md.result_rd    = rd_q;
    assign md.busy         = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb/tb_ex_muldiv_ctrl.sv - self-checking bench for ex_muldiv_ctrl against an arithmetic RV32M model
module tb_ex_muldiv_ctrl;
    import core_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_ctrl_if #(.XLEN(XLEN)) mif();

    ex_muldiv_ctrl #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (mif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t dir_vecs [12] = '{
        '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{F3_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
        '{F3_DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF},
        '{F3_REMU,   32'd100,        32'd0,         32'd100},
        '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
        '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
        '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
        '{F3_REMU,   32'd7,          32'd2,         32'd1},
        '{F3_DIVU,   32'hFFFF_FFFF,  32'd3,         32'h5555_5555}
    };

    function automatic logic [31:0] ref_md(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        case (f3)
            F3_MUL: begin
                up = {32'b0, a} * {32'b0, b};
                return up[31:0];
            end
            F3_MULH: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp[63:32];
            end
            F3_MULHSU: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return sp[63:32];
            end
            F3_MULHU: begin
                up = {32'b0, a} * {32'b0, b};
                return up[63:32];
            end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            F3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_latency(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 2;
`endif
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output int lat);
        mif.funct3       = f3;
        mif.op_a         = a;
        mif.op_b         = b;
        mif.rd_in        = rd;
        mif.result_ready = 1'b1;
        mif.start        = 1'b1;
        lat = 0;
        do begin
            tick();
            mif.start = 1'b0;
            lat++;
        end while (mif.result_valid !== 1'b1 && lat < 100);
        res = mif.result;
        rdo = mif.result_rd;
        tick();
    endtask

    task automatic test_reset();
        mif.start = 0; mif.funct3 = 0; mif.op_a = 0; mif.op_b = 0; mif.rd_in = 0;
        mif.flush = 0; mif.result_ready = 0;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (mif.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mif.result_valid); end
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mif.busy); end
        checks++; if (mif.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", mif.result); end
        checks++; if (mif.result_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", mif.result_rd); end
        checks++; if (mif.md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", mif.md_stall); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run_op(dir_vecs[i].f3, dir_vecs[i].a, dir_vecs[i].b, 5'(i + 1), res, rdo, lat);
            checks++;
            if (res !== dir_vecs[i].e) begin
                errors++;
                $display("FAIL directed_%0d result got %h want %h", i, res, dir_vecs[i].e);
            end
            checks++;
            if (lat != exp_latency(dir_vecs[i].f3, dir_vecs[i].a, dir_vecs[i].b)) begin
                errors++;
                $display("FAIL directed_%0d latency got %0d want %0d", i, lat,
                         exp_latency(dir_vecs[i].f3, dir_vecs[i].a, dir_vecs[i].b));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res;
        logic [4:0]  rd, rdo;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            run_op(f3, a, b, rd, res, rdo, lat);
            checks++;
            if (res !== ref_md(f3, a, b)) begin
                errors++;
                $display("FAIL random f3=%0d a=%h b=%h got %h want %h", f3, a, b, res, ref_md(f3, a, b));
            end
            checks++;
            if (rdo !== rd) begin errors++; $display("FAIL random_rd got %0d want %0d", rdo, rd); end
            checks++;
            if (lat != exp_latency(f3, a, b)) begin
                errors++;
                $display("FAIL random_latency f3=%0d got %0d want %0d", f3, lat, exp_latency(f3, a, b));
            end
        end
    endtask

    task automatic test_stall();
        int L;
        int bad;
        L = exp_latency(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        bad = 0;
        mif.funct3 = F3_MUL; mif.op_a = 32'd7; mif.op_b = 32'hFFFF_FFFD; mif.rd_in = 5'd3;
        mif.result_ready = 1'b1;
        mif.start = 1'b1;
        #1;
        checks++; if (mif.md_stall !== 1'b1) begin errors++; $display("FAIL stall_issue got %b want 1", mif.md_stall); end
        for (int cyc = 1; cyc <= L; cyc++) begin
            tick();
            mif.start = 1'b0;
            if (cyc < L && (mif.md_stall !== 1'b1 || mif.result_valid !== 1'b0)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_window bad_cycles got %0d want 0", bad); end
        checks++; if (mif.result_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_edge got %b want 1", mif.result_valid); end
        checks++; if (mif.md_stall !== 1'b0) begin errors++; $display("FAIL stall_done_ready got %b want 0", mif.md_stall); end
        checks++; if (mif.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL stall_result got %h want ffffffeb", mif.result); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          n;
        mif.funct3 = F3_DIVU; mif.op_a = 32'd1000; mif.op_b = 32'd7; mif.rd_in = 5'd17;
        mif.result_ready = 1'b0;
        mif.start = 1'b1;
        n = 0;
        do begin
            tick();
            mif.start = 1'b0;
            n++;
        end while (mif.result_valid !== 1'b1 && n < 100);
        checks++; if (n >= 100) begin errors++; $display("FAIL bp_timeout got %0d want <100", n); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (mif.result_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_%0d got %b want 1", k, mif.result_valid); end
            checks++; if (mif.result !== 32'd142) begin errors++; $display("FAIL bp_hold_result_%0d got %h want 8e", k, mif.result); end
            checks++; if (mif.result_rd !== 5'd17) begin errors++; $display("FAIL bp_hold_rd_%0d got %0d want 17", k, mif.result_rd); end
            checks++; if (mif.md_stall !== 1'b1) begin errors++; $display("FAIL bp_hold_stall_%0d got %b want 1", k, mif.md_stall); end
            mif.funct3 = F3_MUL; mif.op_a = 32'd3; mif.op_b = 32'd5; mif.rd_in = 5'd9;
            mif.start = 1'b1;
            tick();
        end
        mif.start = 1'b0;
        mif.result_ready = 1'b1;
        #1;
        checks++; if (mif.md_stall !== 1'b0) begin errors++; $display("FAIL bp_release_stall got %b want 0", mif.md_stall); end
        tick();
        checks++; if (mif.result_valid !== 1'b0 || mif.busy !== 1'b0) begin
            errors++; $display("FAIL bp_idle valid=%b busy=%b want 0 0", mif.result_valid, mif.busy); end
        checks++; if (mif.result !== 32'd142) begin errors++; $display("FAIL bp_after_result got %h want 8e", mif.result); end
        run_op(F3_MUL, 32'd3, 32'd5, 5'd9, res, rdo, lat);
        checks++; if (res !== 32'd15 || rdo !== 5'd9) begin
            errors++; $display("FAIL bp_next_op got %h/%0d want f/9", res, rdo); end
    endtask

    task automatic test_flush();
        int seen;
        mif.funct3 = F3_DIV; mif.op_a = $urandom; mif.op_b = 32'd3; mif.rd_in = 5'd4;
        mif.result_ready = 1'b1;
        mif.start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            mif.start = 1'b0;
        end
        mif.flush = 1'b1;
        tick();
        mif.flush = 1'b0;
        checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", mif.busy); end
        checks++; if (mif.result_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", mif.result_valid); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (mif.result_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result got %0d want 0", seen); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        run_op(F3_MUL, 32'd6, 32'd7, 5'd12, res, rdo, lat);
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL rst_pre_result got %h want 2a", res); end
        mif.funct3 = F3_MUL; mif.op_a = 32'h0001_2345; mif.op_b = 32'h0000_0777; mif.rd_in = 5'd5;
        mif.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            mif.start = 1'b0;
        end
        reset_n = 1'b0;
        tick();
        checks++; if (mif.result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got %h want 0", mif.result); end
        checks++; if (mif.result_rd !== 5'd0) begin errors++; $display("FAIL rst_mid_rd got %0d want 0", mif.result_rd); end
        checks++; if (mif.result_valid !== 1'b0 || mif.busy !== 1'b0 || mif.md_stall !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl valid=%b busy=%b stall=%b want 0 0 0",
                               mif.result_valid, mif.busy, mif.md_stall); end
        reset_n = 1'b1;
        tick();
        run_op(F3_MUL, 32'd1234, 32'd5678, 5'd21, res, rdo, lat);
        checks++; if (res !== ref_md(F3_MUL, 32'd1234, 32'd5678)) begin
            errors++; $display("FAIL rst_fresh_result got %h want %h", res, ref_md(F3_MUL, 32'd1234, 32'd5678)); end
        checks++; if (rdo !== 5'd21) begin errors++; $display("FAIL rst_fresh_rd got %0d want 21", rdo); end
        checks++; if (lat != exp_latency(F3_MUL, 32'd1234, 32'd5678)) begin
            errors++; $display("FAIL rst_fresh_latency got %0d want %0d", lat, exp_latency(F3_MUL, 32'd1234, 32'd5678)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
